tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/tone_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Brief    : Eight-entry note pattern player driving a frequency-divider note
//            input, with beat timing, articulation gap, looping and abort.
// Revision : 1.0
// ============================================================================
module tone_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int BEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] len,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [3:0] note,
    output logic       tone_en,
    output logic       busy,
    output logic [2:0] step,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [PW-1:0] c_presc_last = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] c_tick_last  = TW'(BEAT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          r_state, w_state_n;
    logic [7:0]      r_pat [8];
    logic [2:0]      r_step, w_step_n;
    logic [3:0]      r_note, w_note_n;
    logic [3:0]      r_beat, w_beat_n;
    logic [PW-1:0]   r_presc, w_presc_n;
    logic [TW-1:0]   r_tick, w_tick_n;
    logic            r_done, w_done_n;
    logic            w_end_entry;
    logic [7:0]      w_entry;

    assign w_entry = r_pat[r_step];

    // Pattern store is writable in every state; FETCH reads it one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_pat[i] <= 8'h00;
        end else if (wr_en) begin
            r_pat[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= 3'd0;
            r_note  <= 4'd0;
            r_beat  <= 4'd0;
            r_presc <= '0;
            r_tick  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_note  <= w_note_n;
            r_beat  <= w_beat_n;
            r_presc <= w_presc_n;
            r_tick  <= w_tick_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_step_n    = r_step;
        w_note_n    = r_note;
        w_beat_n    = r_beat;
        w_presc_n   = r_presc;
        w_tick_n    = r_tick;
        w_done_n    = 1'b0;
        w_end_entry = 1'b0;

        case (r_state)
            IDLE: begin
                w_note_n = 4'd0;
                if (start && !stop) begin
                    w_state_n = FETCH;
                    w_step_n  = 3'd0;
                end
            end
            FETCH: begin
                w_note_n  = w_entry[3:0];
                w_beat_n  = w_entry[7:4];
                w_presc_n = '0;
                w_tick_n  = '0;
                if (w_entry[7:4] == 4'd0) begin
                    w_end_entry = 1'b1;
                end else begin
                    w_state_n = PLAY;
                end
            end
            PLAY: begin
                if (r_presc == c_presc_last) begin
                    w_presc_n = '0;
                    if (r_tick == c_tick_last) begin
                        w_tick_n = '0;
                        w_beat_n = r_beat - 4'd1;
                        if (r_beat == 4'd1) w_state_n = GAP;
                    end else begin
                        w_tick_n = r_tick + TW'(1);
                    end
                end else begin
                    w_presc_n = r_presc + PW'(1);
                end
            end
            GAP: begin
                if (r_presc == c_presc_last) begin
                    w_presc_n   = '0;
                    w_end_entry = 1'b1;
                end else begin
                    w_presc_n = r_presc + PW'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase

        // ">=" rather than "==" so a len lowered under step ends the pass
        if (w_end_entry) begin
            if (r_step < len) begin
                w_state_n = FETCH;
                w_step_n  = r_step + 3'd1;
            end else if (loop) begin
                w_state_n = FETCH;
                w_step_n  = 3'd0;
            end else begin
                w_state_n = IDLE;
                w_step_n  = 3'd0;
                w_note_n  = 4'd0;
                w_done_n  = 1'b1;
            end
        end

        if (stop && (r_state != IDLE)) begin
            w_state_n = IDLE;
            w_step_n  = 3'd0;
            w_note_n  = 4'd0;
            w_beat_n  = 4'd0;
            w_presc_n = '0;
            w_tick_n  = '0;
            w_done_n  = 1'b0;
        end
    end

    assign note    = r_note;
    assign tone_en = (r_state == PLAY) && (r_note != 4'd0);
    assign busy    = (r_state != IDLE);
    assign step    = r_step;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tone_sequencer
// Brief    : Self-checking bench for tone_sequencer with a timeline model.
// Revision : 1.0
// ============================================================================
module tb_tone_sequencer;

    localparam int TD = 4;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] len;
    logic       start;
    logic       stop;
    logic       loop;
    logic [3:0] note;
    logic       tone_en;
    logic       busy;
    logic [2:0] step;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_pat [8];

    typedef struct packed {
        logic [3:0] note;
        logic       tone;
        logic       busy;
        logic [2:0] step;
        logic       done;
        logic       step_vld;
    } exp_t;

    exp_t exp_q [$];

    tone_sequencer #(.TICK_DIV(TD), .BEAT_TICKS(BT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .loop(loop), .note(note),
        .tone_en(tone_en), .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic [3:0] n, input logic t, input logic b,
                                 input logic [2:0] s, input logic d, input logic v);
        exp_t e;
        e.note = n; e.tone = t; e.busy = b; e.step = s; e.done = d; e.step_vld = v;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle outputs of one non-looping pass, starting at the FETCH cycle
    function automatic void build_expected(input int last);
        logic [3:0] prev;
        int         d;
        logic [3:0] n;
        prev = 4'd0;
        exp_q.delete();
        for (int i = 0; i <= last; i++) begin
            d = int'(m_pat[i][7:4]);
            n = m_pat[i][3:0];
            push(prev, 1'b0, 1'b1, 3'(i), 1'b0, 1'b1);
            prev = n;
            for (int k = 0; k < d * BT * TD; k++) push(n, n != 4'd0, 1'b1, 3'(i), 1'b0, 1'b1);
            if (d != 0) for (int k = 0; k < TD; k++) push(n, 1'b0, 1'b1, 3'(i), 1'b0, 1'b1);
        end
        push(4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        push(4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endfunction

    task automatic write_entry(input int a, input logic [7:0] d);
        wr_addr = 3'(a);
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        m_pat[a] = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({note, tone_en, busy, step, done} !== 11'd0)
            $display("FAIL reset_state got=%h required=000", {note, tone_en, busy, step, done});
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_sequences();
        int   last;
        exp_t e;
        logic [2:0] s_obs;
        for (int it = 0; it < 13; it++) begin
            case (it)
                0: begin write_entry(0, 8'h25); write_entry(1, 8'h13); last = 1; end
                1: begin write_entry(0, 8'h20); last = 0; end
                2: begin write_entry(0, 8'h07); write_entry(1, 8'h11); last = 1; end
                default: begin
                    for (int i = 0; i < 8; i++)
                        write_entry(i, {4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))});
                    last = int'($urandom_range(0, 7));
                end
            endcase
            len  = 3'(last);
            loop = 1'b0;
            build_expected(last);
            pulse_start();
            for (int c = 0; c < exp_q.size(); c++) begin
                e = exp_q[c];
                @(negedge clk);
                s_obs = e.step_vld ? step : 3'd0;
                n_checks++;
                if ({note, tone_en, busy, s_obs, done} !== {e.note, e.tone, e.busy, e.step, e.done})
                    $display("FAIL seq%0d cycle%0d got note=%0d tone=%b busy=%b step=%0d done=%b required note=%0d tone=%b busy=%b step=%0d done=%b",
                             it, c + 1, note, tone_en, busy, s_obs, done, e.note, e.tone, e.busy, e.step, e.done);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_loop_stop();
        logic [3:0] en;
        logic       et;
        int         k;
        write_entry(0, 8'h11);
        len  = 3'd0;
        loop = 1'b1;
        pulse_start();
        for (int c = 0; c < 39; c++) begin
            k  = c % 13;
            en = (c == 0) ? 4'd0 : 4'd1;
            et = (k >= 1) && (k <= 8);
            @(negedge clk);
            n_checks++;
            if ({note, tone_en, busy, step, done} !== {en, et, 1'b1, 3'd0, 1'b0})
                $display("FAIL loop cycle%0d got note=%0d tone=%b busy=%b step=%0d done=%b required note=%0d tone=%b busy=1 step=0 done=0",
                         c + 1, note, tone_en, busy, step, done, en, et);
            else n_pass++;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        loop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({note, tone_en, busy, step, done} !== 11'd0)
                $display("FAIL stop_idle cycle%0d got=%h required=000", c, {note, tone_en, busy, step, done});
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_stop_same();
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, note} !== 6'd0)
                $display("FAIL start_stop_same cycle%0d got busy=%b done=%b note=%0d required 0 0 0", c, busy, done, note);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_lower();
        int   cnt;
        int   max_step;
        logic seen_done;
        for (int i = 0; i < 8; i++) write_entry(i, {4'd1, 4'(i + 1)});
        len  = 3'd5;
        loop = 1'b0;
        pulse_start();
        for (cnt = 0; cnt < 200 && step != 3'd3; cnt++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (step !== 3'd3) $display("FAIL len_lower_reach got step=%0d required=3", step);
        else n_pass++;
        len       = 3'd1;
        max_step  = 3;
        seen_done = 1'b0;
        for (cnt = 0; cnt < 200; cnt++) begin
            @(posedge clk); #1;
            if (busy && int'(step) > max_step) max_step = int'(step);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen_done !== 1'b1) $display("FAIL len_lower_done got=%b required=1", seen_done);
        else n_pass++;
        n_checks++;
        if (max_step != 3) $display("FAIL len_lower_maxstep got=%0d required=3", max_step);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_play();
        write_entry(0, 8'h25);
        len = 3'd0;
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (tone_en !== 1'b1) $display("FAIL pre_reset_tone got=%b required=1", tone_en);
        else n_pass++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({note, tone_en, busy, step, done} !== 11'd0)
            $display("FAIL async_reset got=%h required=000", {note, tone_en, busy, step, done});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) $display("FAIL post_reset_idle cycle%0d got busy=%b required=0", c, busy);
            else n_pass++;
        end
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        n_checks++;
        if ({busy, tone_en, note} !== 6'b100000)
            $display("FAIL replay_fetch got busy=%b tone=%b note=%0d required 1 0 0", busy, tone_en, note);
        else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({done, busy, tone_en} !== 3'b100)
            $display("FAIL replay_done got done=%b busy=%b tone=%b required 1 0 0", done, busy, tone_en);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 8'h00;
        len     = 3'd0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;
        test_reset();
        test_sequences();
        test_loop_stop();
        test_start_stop_same();
        test_len_lower();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
